sd_req_arbiter: RTL and testbench

Arbitrates the single SD-card emulation request channel of the IO-controller interface (sd_lba / sd_rd / sd_wr / sd_ack) between two drive clients, drive 0 and drive 1 (e.g. floppy and ACSI/IDE). It runs in the clk_sys domain next to the SPI user-IO block and sequences one sector transaction at a time. The client index is the drive index presented to the IO controller. Sector data strobes are steered back to the granted client only, and a hung IO controller is detected by timeout.

---
 rtl/sd_req_arbiter.sv | 116 +++++++++++
 tb/tb_sd_req_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_req_arbiter.sv
// Two-client arbiter for the single SD sector request channel: round-robin grant, timeout on missing ack, strobe steering.
// Grant one cycle after request; clients hold their level request until done/err, and another client waits while one is granted.
module sd_req_arbiter #(
  parameter logic [23:0] ACK_TIMEOUT = 24'd8000000
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [1:0]  req_rd,
  input  logic [1:0]  req_wr,
  input  logic [31:0] req0_lba,
  input  logic [31:0] req1_lba,
  output logic [1:0]  req_busy,
  output logic [1:0]  req_done,
  output logic [1:0]  req_err,
  output logic [31:0] sd_lba,
  output logic [1:0]  sd_rd,
  output logic [1:0]  sd_wr,
  input  logic        sd_ack,
  input  logic        sd_dout_strobe,
  input  logic        sd_din_strobe,
  output logic [1:0]  cl_dout_strobe,
  output logic [1:0]  cl_din_strobe
);

  typedef enum logic [1:0] {IDLE, ISSUE, XFER, DONE} state_t;

  state_t      state, state_nxt;
  logic        gnt, gnt_nxt;
  logic        last_grant, last_nxt;
  logic        op_rd, op_rd_nxt;
  logic [23:0] cnt, cnt_nxt;
  logic [31:0] lba_nxt;
  logic [1:0]  err_nxt;
  logic [1:0]  pending;
  logic [1:0]  gnt_oh;
  logic        pick;
  logic        active;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state      <= IDLE;
      gnt        <= 1'b0;
      last_grant <= 1'b1;
      op_rd      <= 1'b0;
      cnt        <= 24'd0;
      sd_lba     <= 32'd0;
      req_err    <= 2'b00;
    end else begin
      state      <= state_nxt;
      gnt        <= gnt_nxt;
      last_grant <= last_nxt;
      op_rd      <= op_rd_nxt;
      cnt        <= cnt_nxt;
      sd_lba     <= lba_nxt;
      req_err    <= err_nxt;
    end
  end

  always_comb begin
    pending   = req_rd | req_wr;
    gnt_oh    = gnt ? 2'b10 : 2'b01;
    state_nxt = state;
    gnt_nxt   = gnt;
    last_nxt  = last_grant;
    op_rd_nxt = op_rd;
    cnt_nxt   = cnt;
    lba_nxt   = sd_lba;
    err_nxt   = 2'b00;
    pick      = 1'b0;
    case (state)
      IDLE: begin
        if (pending != 2'b00) begin
          // With both pending, the client that did not go last wins.
          pick      = (pending == 2'b11) ? ~last_grant : pending[1];
          gnt_nxt   = pick;
          last_nxt  = pick;
          op_rd_nxt = req_rd[pick];
          lba_nxt   = pick ? req1_lba : req0_lba;
          cnt_nxt   = 24'd0;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (sd_ack) begin
          state_nxt = XFER;
        end else if (!pending[gnt]) begin
          state_nxt = IDLE;
        end else if (cnt == ACK_TIMEOUT - 24'd1) begin
          err_nxt   = gnt_oh;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 24'd1;
        end
      end
      XFER: begin
        if (!sd_ack) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Strobes pass through in ISSUE too: user-IO fetches the first write byte on the sd_wr rise.
  assign active         = (state == ISSUE) || (state == XFER);
  assign req_busy       = active ? gnt_oh : 2'b00;
  assign req_done       = (state == DONE) ? gnt_oh : 2'b00;
  assign sd_rd          = (active && op_rd) ? gnt_oh : 2'b00;
  assign sd_wr          = (active && !op_rd) ? gnt_oh : 2'b00;
  assign cl_dout_strobe = (active && sd_dout_strobe) ? gnt_oh : 2'b00;
  assign cl_din_strobe  = (active && sd_din_strobe) ? gnt_oh : 2'b00;

endmodule

// File: tb/tb_sd_req_arbiter.sv
// Bench for sd_req_arbiter: directed scenarios with literal expectations, then randomized traffic against a transaction-level model.
module tb_sd_req_arbiter;
  localparam logic [23:0] TO = 24'd16;

  logic        clk_sys, reset;
  logic [1:0]  req_rd, req_wr;
  logic [31:0] req0_lba, req1_lba;
  logic [1:0]  req_busy, req_done, req_err, sd_rd, sd_wr, cl_dout_strobe, cl_din_strobe;
  logic [31:0] sd_lba;
  logic        sd_ack, sd_dout_strobe, sd_din_strobe;

  int checks = 0;
  int errors = 0;

  sd_req_arbiter #(.ACK_TIMEOUT(TO)) dut (
    .clk_sys(clk_sys), .reset(reset), .req_rd(req_rd), .req_wr(req_wr),
    .req0_lba(req0_lba), .req1_lba(req1_lba), .req_busy(req_busy), .req_done(req_done),
    .req_err(req_err), .sd_lba(sd_lba), .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack),
    .sd_dout_strobe(sd_dout_strobe), .sd_din_strobe(sd_din_strobe),
    .cl_dout_strobe(cl_dout_strobe), .cl_din_strobe(cl_din_strobe)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: who owns the channel, whether the controller acked,
  // how long it has waited, and whether the transfer just finished.
  int          m_owner = -1;
  int          m_last  = 1;
  int          m_age   = 0;
  bit          m_acked = 0;
  bit          m_fin   = 0;
  bit          m_rd    = 0;
  logic [1:0]  m_err   = 2'b00;
  logic [31:0] m_lba   = 32'd0;
  bit          chk_en  = 0;

  always @(posedge clk_sys) begin : model
    int  c;
    bit  p0, p1;
    if (reset) begin
      m_owner = -1; m_last = 1; m_age = 0; m_acked = 0; m_fin = 0;
      m_err = 2'b00; m_lba = 32'd0;
    end else begin
      m_err = 2'b00;
      if (m_fin) begin
        m_fin   = 0;
        m_owner = -1;
      end else if (m_owner < 0) begin
        p0 = req_rd[0] | req_wr[0];
        p1 = req_rd[1] | req_wr[1];
        if (p0 && p1) c = (m_last == 1) ? 0 : 1;
        else if (p0)  c = 0;
        else if (p1)  c = 1;
        else          c = -1;
        if (c >= 0) begin
          m_owner = c;
          m_rd    = req_rd[c];
          m_lba   = (c == 1) ? req1_lba : req0_lba;
          m_last  = c;
          m_acked = 0;
          m_age   = 0;
        end
      end else if (!m_acked) begin
        if (sd_ack) m_acked = 1;
        else if (!(req_rd[m_owner] | req_wr[m_owner])) m_owner = -1;
        else if (m_age == int'(TO) - 1) begin
          m_err[m_owner] = 1'b1;
          m_owner = -1;
        end else m_age++;
      end else if (!sd_ack) begin
        m_fin = 1;
      end
    end
    chk_en = 1;
  end

  always @(negedge clk_sys) begin : compare
    logic [1:0] oh;
    bit         live;
    if (chk_en) begin
      live = (m_owner >= 0) && !m_fin;
      oh   = (m_owner == 1) ? 2'b10 : 2'b01;
      check("busy",  32'(req_busy),       32'(live ? oh : 2'b00));
      check("done",  32'(req_done),       32'(m_fin ? oh : 2'b00));
      check("err",   32'(req_err),        32'(m_err));
      check("rd",    32'(sd_rd),          32'((live && m_rd) ? oh : 2'b00));
      check("wr",    32'(sd_wr),          32'((live && !m_rd) ? oh : 2'b00));
      check("dout",  32'(cl_dout_strobe), 32'((live && sd_dout_strobe) ? oh : 2'b00));
      check("din",   32'(cl_din_strobe),  32'((live && sd_din_strobe) ? oh : 2'b00));
      check("lba",   sd_lba,              m_lba);
    end
  end

  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  // Called just after the negedge of an ISSUE cycle; returns req_done seen in the DONE cycle.
  task automatic complete(output logic [1:0] who);
    step(); sd_ack = 1'b1;
    step();
    step(); sd_ack = 1'b0;
    step();
    @(negedge clk_sys);
    who = req_done;
  endtask

  initial begin
    int         n, c0, c1, sel;
    logic [1:0] who;
    reset = 1'b1; req_rd = 2'b00; req_wr = 2'b00; req0_lba = 32'd0; req1_lba = 32'd0;
    sd_ack = 1'b0; sd_dout_strobe = 1'b0; sd_din_strobe = 1'b0;
    repeat (3) step();
    @(negedge clk_sys);
    check("reset_outs", 32'({req_busy, req_done, req_err, sd_rd, sd_wr}), 32'd0);
    check("reset_lba", sd_lba, 32'd0);

    // Single read by client 0 with three data strobes.
    step(); reset = 1'b0; req_rd = 2'b01; req0_lba = 32'h0000_1234; req1_lba = 32'hABCD_0001;
    step(); @(negedge clk_sys);
    check("t1_rd", 32'(sd_rd), 32'h1);
    check("t1_lba", sd_lba, 32'h0000_1234);
    step(); sd_ack = 1'b1;
    c0 = 0; c1 = 0;
    for (int k = 0; k < 10; k++) begin
      step(); sd_dout_strobe = (k == 2 || k == 4 || k == 6);
      @(negedge clk_sys);
      c0 += int'(cl_dout_strobe[0]);
      c1 += int'(cl_dout_strobe[1]);
    end
    step(); sd_ack = 1'b0; sd_dout_strobe = 1'b0;
    step(); @(negedge clk_sys);
    check("t1_done", 32'(req_done), 32'h1);
    check("t1_rd_low", 32'(sd_rd), 32'h0);
    check("t1_strobes0", c0, 3);
    check("t1_strobes1", c1, 0);
    req_rd = 2'b00;

    // Simultaneous requests after reset, then alternation.
    step(); reset = 1'b1;
    step(); reset = 1'b0; req_rd = 2'b01; req_wr = 2'b10;
    step(); @(negedge clk_sys);
    check("t2_first_rd", 32'(sd_rd), 32'h1);
    check("t2_first_wr", 32'(sd_wr), 32'h0);
    complete(who);
    check("t2_done0", 32'(who), 32'h1);
    req_rd = 2'b00;
    step(); step(); @(negedge clk_sys);
    check("t2_second_wr", 32'(sd_wr), 32'h2);
    complete(who);
    check("t2_done1", 32'(who), 32'h2);
    req_rd = 2'b01;
    for (int k = 0; k < 4; k++) begin
      step(); step(); @(negedge clk_sys);
      check("t2_alternate", 32'(req_busy), (k % 2 == 1) ? 32'h2 : 32'h1);
      complete(who);
    end
    req_rd = 2'b00; req_wr = 2'b00;

    // Timeout on client 1 read with no ack.
    step(); req_rd = 2'b10;
    step();
    n = 0;
    while (n < 100) begin
      step(); n++;
      @(negedge clk_sys);
      if (req_err != 2'b00) break;
    end
    check("t3_latency", n, 16);
    check("t3_err", 32'(req_err), 32'h2);
    check("t3_rd_low", 32'({sd_rd, req_busy}), 32'h0);
    req_rd = 2'b00;

    // Withdrawal in ISSUE, then in XFER.
    step(); req_rd = 2'b01;
    step(); @(negedge clk_sys);
    check("t4_rd", 32'(sd_rd), 32'h1);
    step(); req_rd = 2'b00;
    step(); @(negedge clk_sys);
    check("t4_withdraw", 32'({sd_rd, req_done, req_err}), 32'h0);
    step(); req_rd = 2'b01;
    step();
    step(); sd_ack = 1'b1;
    step(); req_rd = 2'b00;
    step(); @(negedge clk_sys);
    check("t4_xfer_hold", 32'(sd_rd), 32'h1);
    step(); sd_ack = 1'b0;
    step(); @(negedge clk_sys);
    check("t4_xfer_done", 32'(req_done), 32'h1);

    // Read wins when both bits are set.
    step(); req_rd = 2'b01; req_wr = 2'b01;
    step(); @(negedge clk_sys);
    check("t5_rd", 32'(sd_rd), 32'h1);
    check("t5_wr", 32'(sd_wr), 32'h0);
    req_rd = 2'b00; req_wr = 2'b00;
    step();

    // Reset during XFER of client 0; client 0 still wins afterwards.
    req_rd = 2'b01;
    step();
    step(); sd_ack = 1'b1;
    step(); req_rd = 2'b11; reset = 1'b1;
    step(); @(negedge clk_sys);
    check("t6_reset_outs", 32'({req_busy, req_done, req_err, sd_rd, sd_wr}), 32'h0);
    step(); reset = 1'b0; sd_ack = 1'b0;
    step(); @(negedge clk_sys);
    check("t6_first_grant", 32'(req_busy), 32'h1);
    req_rd = 2'b00;
    step();

    // Randomized traffic checked by the model on every cycle.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk_sys);
      for (int i = 0; i < 2; i++) begin
        if (req_done[i] | req_err[i]) begin
          req_rd[i] = 1'b0; req_wr[i] = 1'b0;
        end
      end
      step();
      reset = ($urandom_range(0, 599) == 0);
      for (int i = 0; i < 2; i++) begin
        if (!(req_rd[i] | req_wr[i])) begin
          if ($urandom_range(0, 3) == 0) begin
            sel = int'($urandom_range(0, 2));
            req_rd[i] = (sel != 1);
            req_wr[i] = (sel != 0);
            if (i == 0) req0_lba = $urandom;
            else        req1_lba = $urandom;
          end
        end else if ($urandom_range(0, 63) == 0) begin
          req_rd[i] = 1'b0; req_wr[i] = 1'b0;
        end
      end
      if (sd_ack)                  sd_ack = ($urandom_range(0, 5) != 0);
      else if ((sd_rd | sd_wr) != 0) sd_ack = ($urandom_range(0, 9) == 0);
      sd_dout_strobe = 1'($urandom_range(0, 1));
      sd_din_strobe  = 1'($urandom_range(0, 1));
    end
    reset = 1'b0;
    step();
    @(negedge clk_sys);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
